// File: rtl/hyperbus_read_burst_sequencer.sv
// ---------------------------------------------------------------------------
// hyperbus_read_burst_sequencer
// Sequences one HyperBus read burst in the RWDS clock domain: discards the
// preamble edges, presents exactly burst_len_i words to the read CDC FIFO
// source port and tags the final word. Words offered while the FIFO is not
// ready are dropped (overflow_o), and RWDS edges after the burst are flagged
// (excess_o).
// Optional feature macro: HYPERBUS_READ_ERR_CNT_EN builds a saturating
// error-event counter on err_cnt_o; without it err_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module hyperbus_read_burst_sequencer #(
    parameter int CNT_W  = 16,
    parameter int SKIP_W = 4
) (
    input  logic              clk_rwds,
    input  logic              resetReadModule,
    input  logic [CNT_W-1:0]  burst_len_i,
    input  logic [SKIP_W-1:0] skip_edges_i,
    input  logic [15:0]       src_data_i,
    input  logic              fifo_ready_i,
    output logic              fifo_valid_o,
    output logic [16:0]       fifo_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic              excess_o,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_overflow;
    logic              r_excess;

    state_t            w_reset_state;
    logic              w_skip_last;
    logic              w_last_word;
    logic              w_drop;

    // State entered while reset is held: the preamble is skipped only when
    // there is one; a zero-length burst with no preamble is done at once.
    always_comb begin
        w_reset_state = ST_SKIP;
        if (skip_edges_i != {SKIP_W{1'b0}}) begin
            w_reset_state = ST_SKIP;
        end else if (burst_len_i == {CNT_W{1'b0}}) begin
            w_reset_state = ST_DONE;
        end else begin
            w_reset_state = ST_CAPTURE;
        end
    end

    // Last preamble edge, last word of the stream, and a word offered while
    // the FIFO cannot take it. The word counter stops at burst_len_i, so the
    // last-word compare is false once DONE is reached.
    assign w_skip_last = (r_skip_cnt == (skip_edges_i - SKIP_W'(1)));
    assign w_last_word = (r_word_cnt == (burst_len_i - CNT_W'(1)));
    assign w_drop      = (r_state == ST_CAPTURE) && !fifo_ready_i;

    // Burst FSM: preamble skip, word stream counted by position (accepted or
    // dropped alike), then a terminal DONE that only flags stray edges.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            r_state    <= w_reset_state;
            r_skip_cnt <= {SKIP_W{1'b0}};
            r_word_cnt <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
            r_excess   <= 1'b0;
        end else begin
            case (r_state)
                ST_SKIP: begin
                    r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
                    if (w_skip_last) begin
                        r_state <= (burst_len_i == {CNT_W{1'b0}}) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_last_word) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_excess <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: park in the terminal state so
                    // nothing further is pushed to the FIFO.
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

`ifdef HYPERBUS_READ_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err_evt;

    assign w_err_evt = w_drop || (r_state == ST_DONE);

    // Saturating count of dropped words and post-burst edges.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 8'h00;
`endif

    // Valid is decoded from the state register only; data passes straight
    // through from the capture registers with the position-based last tag.
    assign fifo_valid_o = (r_state == ST_CAPTURE);
    assign fifo_data_o  = {w_last_word, src_data_i};
    assign busy_o       = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
    assign done_o       = (r_state == ST_DONE);
    assign overflow_o   = r_overflow;
    assign excess_o     = r_excess;

endmodule

// File: tb/tb_hyperbus_read_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_read_burst_sequencer
// Directed vector table of {inputs, expected outputs} plus hand-written
// sequences for the long preamble and error-counter saturation.
// ---------------------------------------------------------------------------
module tb_hyperbus_read_burst_sequencer;

    logic        clk_rwds;
    logic        resetReadModule;
    logic [15:0] burst_len_i;
    logic [3:0]  skip_edges_i;
    logic [15:0] src_data_i;
    logic        fifo_ready_i;
    logic        fifo_valid_o;
    logic [16:0] fifo_data_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;
    logic        excess_o;
    logic [7:0]  err_cnt_o;

    hyperbus_read_burst_sequencer #(.CNT_W(16), .SKIP_W(4)) dut (
        .clk_rwds        (clk_rwds),
        .resetReadModule (resetReadModule),
        .burst_len_i     (burst_len_i),
        .skip_edges_i    (skip_edges_i),
        .src_data_i      (src_data_i),
        .fifo_ready_i    (fifo_ready_i),
        .fifo_valid_o    (fifo_valid_o),
        .fifo_data_o     (fifo_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .overflow_o      (overflow_o),
        .excess_o        (excess_o),
        .err_cnt_o       (err_cnt_o)
    );

    typedef struct {
        bit          rst;      // pulse reset with these inputs first
        bit          clk_edge; // apply one clk_rwds edge after pre-edge check
        logic [3:0]  skip;
        logic [15:0] len;
        logic [15:0] data;
        bit          ready;
        bit          ev;       // expected valid before the edge
        bit          el;       // expected last before the edge (if valid)
        bit          eb;       // expected busy after the edge
        bit          ed;       // expected done after the edge
        bit          eo;       // expected overflow after the edge
        bit          ee;       // expected excess after the edge
        logic [7:0]  err;      // expected err count with counter built
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_miss;

    task automatic add(input bit rst, input bit ce, input logic [3:0] skip,
                       input logic [15:0] len, input logic [15:0] data, input bit ready,
                       input bit ev, input bit el, input bit eb, input bit ed,
                       input bit eo, input bit ee, input logic [7:0] err);
        vec_t v;
        v.rst = rst; v.clk_edge = ce; v.skip = skip; v.len = len; v.data = data;
        v.ready = ready; v.ev = ev; v.el = el; v.eb = eb; v.ed = ed;
        v.eo = eo; v.ee = ee; v.err = err;
        vq.push_back(v);
    endtask

    function automatic logic [7:0] exp_err(input logic [7:0] with_cnt);
`ifdef HYPERBUS_READ_ERR_CNT_EN
        return with_cnt;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clk_rwds pulse; outputs are then sampled mid-low-phase.
    task automatic pulse();
        clk_rwds = 1'b1;
        #5;
        clk_rwds = 1'b0;
        #4;
    endtask

    task automatic do_reset();
        resetReadModule = 1'b1;
        #2;
        resetReadModule = 1'b0;
    endtask

    initial begin
        clk_rwds        = 1'b0;
        resetReadModule = 1'b0;
        burst_len_i     = 16'd0;
        skip_edges_i    = 4'd0;
        src_data_i      = 16'h0000;
        fifo_ready_i    = 1'b1;
        n_vec           = 0;
        n_miss          = 0;
        #3;

        // skip=2, len=4: two preamble edges, A0..A3 on edges 3..6
        add(1,0,4'd2,16'd4,16'h0000,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'h0011,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'h0022,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'hA0A0,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'hA1A1,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'hA2A2,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd2,16'd4,16'hA3A3,1, 1,1, 0,1,0,0,8'd0);
        // skip=0, len=1: valid+last straight out of reset
        add(1,0,4'd0,16'd1,16'hB0B0,1, 1,1, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd1,16'hB0B0,1, 1,1, 0,1,0,0,8'd0);
        // skip=1, len=4, ready low on the 3rd data edge
        add(1,0,4'd1,16'd4,16'h0000,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd1,16'd4,16'h0000,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd1,16'd4,16'hC001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd1,16'd4,16'hC002,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd1,16'd4,16'hC003,0, 1,0, 1,0,1,0,8'd1);
        add(0,1,4'd1,16'd4,16'hC004,1, 1,1, 0,1,1,0,8'd1);
        // len=2, skip=0, 5 edges: excess from edge 3
        add(1,0,4'd0,16'd2,16'hD001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'hD001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'hD002,1, 1,1, 0,1,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'hD003,1, 0,0, 0,1,0,1,8'd1);
        add(0,1,4'd0,16'd2,16'hD004,1, 0,0, 0,1,0,1,8'd2);
        add(0,1,4'd0,16'd2,16'hD005,1, 0,0, 0,1,0,1,8'd3);
        // len=8 with a drop, reset after 3 data edges, then a len=2 burst
        add(1,0,4'd0,16'd8,16'hE001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd8,16'hE001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd8,16'hE002,0, 1,0, 1,0,1,0,8'd1);
        add(0,1,4'd0,16'd8,16'hE003,1, 1,0, 1,0,1,0,8'd1);
        add(1,0,4'd0,16'd2,16'hF001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'hF001,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'hF002,1, 1,1, 0,1,0,0,8'd0);
        // drop on the final word: overflow and DONE on the same edge
        add(1,0,4'd0,16'd2,16'h1111,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'h1111,1, 1,0, 1,0,0,0,8'd0);
        add(0,1,4'd0,16'd2,16'h2222,0, 1,1, 0,1,1,0,8'd1);
        // len=0, skip=3: never valid, DONE after edge 3
        add(1,0,4'd3,16'd0,16'h3333,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd3,16'd0,16'h3334,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd3,16'd0,16'h3335,1, 0,0, 1,0,0,0,8'd0);
        add(0,1,4'd3,16'd0,16'h3336,1, 0,0, 0,1,0,0,8'd0);

        foreach (vq[i]) begin
            skip_edges_i = vq[i].skip;
            burst_len_i  = vq[i].len;
            src_data_i   = vq[i].data;
            fifo_ready_i = vq[i].ready;
            if (vq[i].rst) do_reset();
            #1;
            chk($sformatf("v%0d valid", i), {31'd0, fifo_valid_o}, {31'd0, vq[i].ev});
            chk($sformatf("v%0d data", i), {16'd0, fifo_data_o[15:0]}, {16'd0, vq[i].data});
            if (vq[i].ev) chk($sformatf("v%0d last", i), {31'd0, fifo_data_o[16]}, {31'd0, vq[i].el});
            if (vq[i].clk_edge) pulse();
            #1;
            chk($sformatf("v%0d busy", i), {31'd0, busy_o}, {31'd0, vq[i].eb});
            chk($sformatf("v%0d done", i), {31'd0, done_o}, {31'd0, vq[i].ed});
            chk($sformatf("v%0d overflow", i), {31'd0, overflow_o}, {31'd0, vq[i].eo});
            chk($sformatf("v%0d excess", i), {31'd0, excess_o}, {31'd0, vq[i].ee});
            chk($sformatf("v%0d err_cnt", i), {24'd0, err_cnt_o}, {24'd0, exp_err(vq[i].err)});
            n_vec++;
        end

        // Continuing in DONE from the len=0 burst: 300 stray edges saturate the counter
        for (int k = 1; k <= 300; k++) begin
            pulse();
            #1;
            if (k == 254) begin
                chk("sat edge254 err_cnt", {24'd0, err_cnt_o}, {24'd0, exp_err(8'hFE)});
                n_vec++;
            end
            if (k == 255) begin
                chk("sat edge255 err_cnt", {24'd0, err_cnt_o}, {24'd0, exp_err(8'hFF)});
                n_vec++;
            end
        end
        chk("sat edge300 err_cnt", {24'd0, err_cnt_o}, {24'd0, exp_err(8'hFF)});
        chk("sat excess", {31'd0, excess_o}, 32'd1);
        chk("sat valid", {31'd0, fifo_valid_o}, 32'd0);
        chk("sat done", {31'd0, done_o}, 32'd1);
        n_vec++;

        // Longest preamble: skip=15, len=3
        skip_edges_i = 4'd15;
        burst_len_i  = 16'd3;
        fifo_ready_i = 1'b1;
        do_reset();
        #1;
        chk("skip15 reset err_cnt", {24'd0, err_cnt_o}, 32'd0);
        for (int k = 1; k <= 14; k++) pulse();
        #1;
        chk("skip15 edge14 valid", {31'd0, fifo_valid_o}, 32'd0);
        chk("skip15 edge14 busy", {31'd0, busy_o}, 32'd1);
        pulse();
        #1;
        chk("skip15 edge15 valid", {31'd0, fifo_valid_o}, 32'd1);
        chk("skip15 edge15 last", {31'd0, fifo_data_o[16]}, 32'd0);
        pulse();
        pulse();
        #1;
        chk("skip15 word3 last", {31'd0, fifo_data_o[16]}, 32'd1);
        pulse();
        #1;
        chk("skip15 done", {31'd0, done_o}, 32'd1);
        chk("skip15 overflow", {31'd0, overflow_o}, 32'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
